zmips_mem_arbiter: RTL and testbench

Single-port memory arbiter for the zmips core. It lets the instruction-fetch port and the load/store port share one unified memory, so the split instruction/data memories can be replaced by a single RAM. It grants one transaction at a time, registers the memory-side request, and returns data with a one-cycle `ready` pulse. A watchdog aborts transactions that the memory never acknowledges.

---
 rtl/zmips_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_zmips_mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/zmips_mem_arbiter.sv
// rtl/zmips_mem_arbiter.sv - shares one memory port between fetch and load/store with a timeout watchdog
// Optional round-robin arbitration when ZMIPS_ARB_FAIR_EN is defined; fixed data-over-fetch priority otherwise.
module zmips_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_data,
  output logic          i_ready,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_data_o,
  output logic [DW-1:0] d_data_i,
  output logic          d_ready,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_rd,
  output logic          m_wr,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] cnt;
  logic        i_elig;
  logic        d_elig;
  logic        grant_i;
  logic        grant_d;

  // A requester whose ready is high this cycle may still be dropping its request.
  assign i_elig = i_req && !i_ready;
  assign d_elig = (d_rd || d_wr) && !d_ready;

`ifdef ZMIPS_ARB_FAIR_EN
  logic last_grant;  // 0: fetch won last, 1: data won last

  assign grant_d = d_elig && (!i_elig || !last_grant);
`else
  assign grant_d = d_elig;
`endif
  assign grant_i = i_elig && !grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      i_data   <= '0;
      d_data_i <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_rd     <= 1'b0;
      m_wr     <= 1'b0;
      i_ready  <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
`ifdef ZMIPS_ARB_FAIR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            m_addr  <= d_addr;
            m_wdata <= d_data_o;
            m_wr    <= d_wr;
            m_rd    <= !d_wr;
            cnt     <= '0;
            state   <= DBUSY;
`ifdef ZMIPS_ARB_FAIR_EN
            last_grant <= 1'b1;
`endif
          end else if (grant_i) begin
            m_addr  <= i_addr;
            m_wdata <= d_data_o;
            m_wr    <= 1'b0;
            m_rd    <= 1'b1;
            cnt     <= '0;
            state   <= IBUSY;
`ifdef ZMIPS_ARB_FAIR_EN
            last_grant <= 1'b0;
`endif
          end
        end
        IBUSY, DBUSY: begin
          if (m_ack) begin
            m_rd  <= 1'b0;
            m_wr  <= 1'b0;
            state <= IDLE;
            if (state == IBUSY) begin
              i_data  <= m_rdata;
              i_ready <= 1'b1;
            end else begin
              if (!m_wr) d_data_i <= m_rdata;
              d_ready <= 1'b1;
            end
          end else if (cnt == TMO) begin
            // Abort: complete the handshake with err but leave the data registers alone.
            m_rd  <= 1'b0;
            m_wr  <= 1'b0;
            err   <= 1'b1;
            state <= IDLE;
            if (state == IBUSY) i_ready <= 1'b1;
            else                d_ready <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zmips_mem_arbiter.sv
// tb/tb_zmips_mem_arbiter.sv - cycle-vector bench for zmips_mem_arbiter with TIMEOUT=4
module tb_zmips_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_ready;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_data_o;
  logic [31:0] d_data_i;
  logic        d_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_rd;
  logic        m_wr;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zmips_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_o(d_data_o),
    .d_data_i(d_data_i), .d_ready(d_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );

  // One record per clock: inputs sampled at the edge, outputs expected just after it.
  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic        e_ir;
    logic        e_dr;
    logic        e_err;
    logic [31:0] e_idata;
    logic [31:0] e_ddata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dd, input logic ak,
                              input logic [31:0] rd, input logic erd, input logic ewr,
                              input logic [31:0] ea, input logic eir, input logic edr,
                              input logic eerr, input logic [31:0] eid, input logic [31:0] edd);
    vec_t v;
    v.i_req = ir; v.i_addr = ia; v.d_rd = dr; v.d_wr = dw; v.d_addr = da; v.d_wdata = dd;
    v.m_ack = ak; v.m_rdata = rd; v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea;
    v.e_ir = eir; v.e_dr = edr; v.e_err = eerr; v.e_idata = eid; v.e_ddata = edd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_data_o = 0; m_ack = 0; m_rdata = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset m_rd", 32'(m_rd), 0);
    check("reset m_wr", 32'(m_wr), 0);
    check("reset m_addr", m_addr, 0);
    check("reset m_wdata", m_wdata, 0);
    check("reset readies", {30'd0, i_ready, d_ready}, 0);
    check("reset err", 32'(err), 0);
    check("reset i_data", i_data, 0);
    check("reset d_data_i", d_data_i, 0);
    @(negedge clk);
    rst = 1'b1;

    // fetch only, ack in the first strobe cycle
    add(1, 32'h10, 0, 0, 0, 0, 0, 0,                   1, 0, 32'h10, 0, 0, 0, 0, 0);
    add(1, 32'h10, 0, 0, 0, 0, 1, 32'h2002_0005,       0, 0, 32'h10, 1, 0, 0, 32'h2002_0005, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h10, 0, 0, 0, 32'h2002_0005, 0);
    // write 0xDEADBEEF to 0x40, ack in third strobe cycle; rdata during write is ignored
    add(0, 0, 0, 1, 32'h40, 32'hDEAD_BEEF, 0, 0,       0, 1, 32'h40, 0, 0, 0, 32'h2002_0005, 0);
    add(0, 0, 0, 1, 32'h40, 32'hDEAD_BEEF, 0, 0,       0, 1, 32'h40, 0, 0, 0, 32'h2002_0005, 0);
    add(0, 0, 0, 1, 32'h40, 32'hDEAD_BEEF, 0, 0,       0, 1, 32'h40, 0, 0, 0, 32'h2002_0005, 0);
    add(0, 0, 0, 1, 32'h40, 32'hDEAD_BEEF, 1, 32'h1234_5678, 0, 0, 32'h40, 0, 1, 0, 32'h2002_0005, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h40, 0, 0, 0, 32'h2002_0005, 0);
    // read back 0x40, then hold d_rd through d_ready
    add(0, 0, 1, 0, 32'h40, 0, 0, 0,                   1, 0, 32'h40, 0, 0, 0, 32'h2002_0005, 0);
    add(0, 0, 1, 0, 32'h40, 0, 1, 32'hDEAD_BEEF,       0, 0, 32'h40, 0, 1, 0, 32'h2002_0005, 32'hDEAD_BEEF);
    add(0, 0, 1, 0, 32'h44, 0, 0, 0,                   0, 0, 32'h40, 0, 0, 0, 32'h2002_0005, 32'hDEAD_BEEF);
    add(0, 0, 1, 0, 32'h44, 0, 0, 0,                   1, 0, 32'h44, 0, 0, 0, 32'h2002_0005, 32'hDEAD_BEEF);
    add(0, 0, 1, 0, 32'h44, 0, 1, 32'h0BAD_F00D,       0, 0, 32'h44, 0, 1, 0, 32'h2002_0005, 32'h0BAD_F00D);
    add(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h44, 0, 0, 0, 32'h2002_0005, 32'h0BAD_F00D);
    // simultaneous fetch and data read: data first, fetch granted in the d_ready cycle
    add(1, 32'h100, 1, 0, 32'h200, 0, 0, 0,            1, 0, 32'h200, 0, 0, 0, 32'h2002_0005, 32'h0BAD_F00D);
    add(1, 32'h100, 1, 0, 32'h200, 0, 1, 32'hAAAA_0001, 0, 0, 32'h200, 0, 1, 0, 32'h2002_0005, 32'hAAAA_0001);
    add(1, 32'h100, 0, 0, 0, 0, 0, 0,                  1, 0, 32'h100, 0, 0, 0, 32'h2002_0005, 32'hAAAA_0001);
    add(1, 32'h100, 0, 0, 0, 0, 1, 32'h5555_0002,      0, 0, 32'h100, 1, 0, 0, 32'h5555_0002, 32'hAAAA_0001);
    add(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h100, 0, 0, 0, 32'h5555_0002, 32'hAAAA_0001);
    // timeout: strobe high 5 cycles, then d_ready+err, data unchanged
    for (int k = 0; k < 5; k++)
      add(0, 0, 1, 0, 32'h300, 0, 0, 32'hFFFF_FFFF,    1, 0, 32'h300, 0, 0, 0, 32'h5555_0002, 32'hAAAA_0001);
    add(0, 0, 1, 0, 32'h300, 0, 0, 32'hFFFF_FFFF,      0, 0, 32'h300, 0, 1, 1, 32'h5555_0002, 32'hAAAA_0001);
    add(1, 32'h20, 0, 0, 0, 0, 0, 0,                   1, 0, 32'h20, 0, 0, 0, 32'h5555_0002, 32'hAAAA_0001);
    add(1, 32'h20, 0, 0, 0, 0, 1, 32'h0000_0077,       0, 0, 32'h20, 1, 0, 0, 32'h0000_0077, 32'hAAAA_0001);
    add(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h20, 0, 0, 0, 32'h0000_0077, 32'hAAAA_0001);

    foreach (vecs[n]) begin
      @(negedge clk);
      i_req = vecs[n].i_req; i_addr = vecs[n].i_addr; d_rd = vecs[n].d_rd; d_wr = vecs[n].d_wr;
      d_addr = vecs[n].d_addr; d_data_o = vecs[n].d_wdata; m_ack = vecs[n].m_ack; m_rdata = vecs[n].m_rdata;
      @(posedge clk);
      #1;
      check($sformatf("v%0d m_rd", n), 32'(m_rd), 32'(vecs[n].e_rd));
      check($sformatf("v%0d m_wr", n), 32'(m_wr), 32'(vecs[n].e_wr));
      check($sformatf("v%0d m_addr", n), m_addr, vecs[n].e_addr);
      check($sformatf("v%0d i_ready", n), 32'(i_ready), 32'(vecs[n].e_ir));
      check($sformatf("v%0d d_ready", n), 32'(d_ready), 32'(vecs[n].e_dr));
      check($sformatf("v%0d err", n), 32'(err), 32'(vecs[n].e_err));
      check($sformatf("v%0d i_data", n), i_data, vecs[n].e_idata);
      check($sformatf("v%0d d_data_i", n), d_data_i, vecs[n].e_ddata);
    end

    // reset in DBUSY with write strobe high, then a late ack after release
    @(negedge clk);
    d_wr = 1; d_addr = 32'h80; d_data_o = 32'h0000_CAFE;
    @(posedge clk);
    #1;
    check("rst_seq m_wr before", 32'(m_wr), 1);
    check("rst_seq m_wdata before", m_wdata, 32'h0000_CAFE);
    #2;
    rst = 1'b0;
    #1;
    check("rst_seq m_wr", 32'(m_wr), 0);
    check("rst_seq m_addr", m_addr, 0);
    check("rst_seq readies", {30'd0, i_ready, d_ready}, 0);
    check("rst_seq i_data", i_data, 0);
    check("rst_seq d_data_i", d_data_i, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    m_ack = 1; m_rdata = 32'h9999_9999;
    @(posedge clk);
    #1;
    check("late_ack d_ready", 32'(d_ready), 0);
    check("late_ack strobes", {30'd0, m_rd, m_wr}, 0);
    check("late_ack d_data_i", d_data_i, 0);
    @(negedge clk);
    m_ack = 0;
    i_req = 1; i_addr = 32'h0000_0abc;
    @(posedge clk);
    #1;
    check("post_rst grant m_rd", 32'(m_rd), 1);
    check("post_rst grant m_addr", m_addr, 32'h0000_0abc);
    @(negedge clk);
    m_ack = 1; m_rdata = 32'h1357_2468;
    @(posedge clk);
    #1;
    check("post_rst i_ready", 32'(i_ready), 1);
    check("post_rst i_data", i_data, 32'h1357_2468);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
